fetch_control: RTL and testbench

//  Sequencer that drives PROGRAM_MEMORY's fetch controls (pc_mux_sel, jump_loc, stall, stall_pm).

---
 rtl/fetch_control.sv | 169 ++++++++++++++++
 tb/tb_fetch_control.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
`default_nettype none
// ============================================================================
// fetch_control : fetch sequencer and IF/ID register (jumps, branches, flush,
//                 one-cycle load-use freeze)
// Revision      : 1.0
// ============================================================================
module fetch_control #(
  parameter int         FLUSH_CYCLES = 1,
  parameter logic [5:0] OP_J         = 6'h02,
  parameter logic [5:0] OP_LW        = 6'h23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic [15:0] current_address,
  input  logic        ex_br_taken,
  input  logic [15:0] ex_br_target,
  output logic        pc_mux_sel,
  output logic [15:0] jump_loc,
  output logic        stall,
  output logic        stall_pm,
  output logic [31:0] id_ins,
  output logic [15:0] id_pc,
  output logic        id_valid,
  output logic        issue_valid
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [31:0]      id_ins_q,   id_ins_d;
  logic [15:0]      id_pc_q,    id_pc_d;
  logic             id_valid_q, id_valid_d;
  logic             lu_valid_q, lu_valid_d;
  logic [4:0]       lu_rt_q,    lu_rt_d;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       br_redirect;
  logic       j_redirect;
  logic       hazard;
  logic       hold;

  assign op = id_ins_q[31:26];
  assign rs = id_ins_q[25:21];
  assign rt = id_ins_q[20:16];

  always_comb begin
    br_redirect = ex_br_taken && (state_q != ST_BOOT);
    j_redirect  = (state_q == ST_RUN) && id_valid_q && (op == OP_J);
    hazard      = (state_q == ST_RUN) && id_valid_q && lu_valid_q &&
                  (lu_rt_q != 5'd0) && (op != OP_J) &&
                  ((rs == lu_rt_q) || (rt == lu_rt_q));
    // A taken branch kills the stalled instruction anyway, so it overrides the freeze.
    hold        = hazard && !br_redirect;
  end

  always_comb begin
    pc_mux_sel  = !(br_redirect || j_redirect);
    jump_loc    = br_redirect ? ex_br_target : id_ins_q[15:0];
    stall       = hold;
    stall_pm    = hold;
    id_ins      = id_ins_q;
    id_pc       = id_pc_q;
    id_valid    = id_valid_q;
    issue_valid = id_valid_q && !hold;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_ins_d   = id_ins_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    lu_valid_d = lu_valid_q;
    lu_rt_d    = lu_rt_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (br_redirect) begin
          state_d    = ST_FLUSH;
          cnt_d      = '0;
          id_ins_d   = '0;
          id_pc_d    = '0;
          id_valid_d = 1'b0;
          lu_valid_d = 1'b0;
        end else if (j_redirect) begin
          state_d    = ST_FLUSH;
          cnt_d      = '0;
          id_ins_d   = '0;
          id_pc_d    = '0;
          id_valid_d = 1'b0;
          lu_valid_d = 1'b0;
          lu_rt_d    = rt;
        end else if (hold) begin
          lu_valid_d = 1'b0;
        end else begin
          id_ins_d   = ins;
          id_pc_d    = current_address;
          id_valid_d = 1'b1;
          if (id_valid_q) begin
            lu_valid_d = (op == OP_LW);
            lu_rt_d    = rt;
          end
        end
      end

      ST_FLUSH: begin
        if (br_redirect) begin
          cnt_d      = '0;
          id_ins_d   = '0;
          id_pc_d    = '0;
          id_valid_d = 1'b0;
          lu_valid_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          // Redirect target is on the fetch bus now; capture it as we leave.
          state_d    = ST_RUN;
          id_ins_d   = ins;
          id_pc_d    = current_address;
          id_valid_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          id_ins_d   = '0;
          id_pc_d    = '0;
          id_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      cnt_q      <= '0;
      id_ins_q   <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      lu_valid_q <= 1'b0;
      lu_rt_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_ins_q   <= id_ins_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      lu_valid_q <= lu_valid_d;
      lu_rt_q    <= lu_rt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_control.sv
`default_nettype none
// ============================================================================
// tb_fetch_control : bench for fetch_control with a one-cycle-latency program
//                    memory model and an issue-order scoreboard
// Revision         : 1.0
// ============================================================================
module tb_fetch_control;

  localparam logic [5:0] OP_J  = 6'h02;
  localparam logic [5:0] OP_LW = 6'h23;

  logic        clk;
  logic        reset;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic        ex_br_taken;
  logic [15:0] ex_br_target;
  logic        pc_mux_sel;
  logic [15:0] jump_loc;
  logic        stall;
  logic        stall_pm;
  logic [31:0] id_ins;
  logic [15:0] id_pc;
  logic        id_valid;
  logic        issue_valid;

  int errors = 0;
  int checks = 0;

  fetch_control #(
    .FLUSH_CYCLES(1),
    .OP_J        (OP_J),
    .OP_LW       (OP_LW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ins            (ins),
    .current_address(current_address),
    .ex_br_taken    (ex_br_taken),
    .ex_br_target   (ex_br_target),
    .pc_mux_sel     (pc_mux_sel),
    .jump_loc       (jump_loc),
    .stall          (stall),
    .stall_pm       (stall_pm),
    .id_ins         (id_ins),
    .id_pc          (id_pc),
    .id_valid       (id_valid),
    .issue_valid    (issue_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: the word for the address chosen at an edge is presented after it.
  logic [31:0] mem [0:255];
  logic [15:0] pm_pc;
  logic [31:0] pm_word;
  logic [15:0] fetch_addr;

  assign fetch_addr      = !pc_mux_sel ? jump_loc : (stall ? pm_pc : pm_pc + 16'd1);
  assign ins             = pm_word;
  assign current_address = pm_pc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pm_pc   <= 16'hFFFF;
      pm_word <= '0;
    end else begin
      pm_pc <= fetch_addr;
      if (!stall_pm) pm_word <= mem[fetch_addr[7:0]];
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Scoreboard of instructions expected to issue, in order.
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  bit   sb_on = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (sb_on && reset && issue_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_issue unexpected issue id_pc=%h id_ins=%h", id_pc, id_ins);
      end else begin
        sb_e = sb_q.pop_front();
        if (id_pc !== sb_e.pc || id_ins !== sb_e.word) begin
          errors++;
          $display("FAIL sb_issue got pc=%h ins=%h exp pc=%h ins=%h",
                   id_pc, id_ins, sb_e.pc, sb_e.word);
        end
      end
    end
  end

  task automatic sb_push(input int a);
    exp_t e;
    e.pc   = 16'(a);
    e.word = mem[a];
    sb_q.push_back(e);
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 256; a++) mem[a] = mk(6'h00, 5'd1, 5'd2, {a[7:0], 8'h20});
  endtask

  task automatic apply_reset();
    sb_on = 1'b0;
    sb_q.delete();
    ex_br_taken  = 1'b0;
    ex_br_target = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    int waited;
    fill_mem();
    reset        = 1'b0;
    ex_br_taken  = 1'b1;
    ex_br_target = 16'hBEEF;
    repeat (2) cyc();
    checks++; if (pc_mux_sel !== 1'b1) begin errors++; $display("FAIL rst_pc_mux_sel got=%b exp=1", pc_mux_sel); end
    checks++; if (jump_loc !== 16'h0000) begin errors++; $display("FAIL rst_jump_loc got=%h exp=0000", jump_loc); end
    checks++; if (stall !== 1'b0 || stall_pm !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b/%b exp=0/0", stall, stall_pm); end
    checks++; if (id_ins !== 32'h0 || id_pc !== 16'h0) begin errors++; $display("FAIL rst_ifid got ins=%h pc=%h exp 0/0", id_ins, id_pc); end
    checks++; if (id_valid !== 1'b0 || issue_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b/%b exp=0/0", id_valid, issue_valid); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL boot_id_valid got=%b exp=0", id_valid); end
    checks++; if (pc_mux_sel !== 1'b1) begin errors++; $display("FAIL boot_ignores_branch pc_mux_sel got=%b exp=1", pc_mux_sel); end
    @(negedge clk);
    ex_br_taken = 1'b0;
    #1;
    waited = 1;
    while (id_valid !== 1'b1 && waited < 6) begin
      cyc();
      waited++;
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0000 || id_ins !== mem[0]) begin
      errors++;
      $display("FAIL boot_first_fetch got valid=%b pc=%h ins=%h exp 1/0000/%h", id_valid, id_pc, id_ins, mem[0]);
    end
  endtask

  task automatic test_stream();
    fill_mem();
    apply_reset();
    for (int k = 0; k < 6; k++) sb_push(k);
    sb_on = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (id_pc !== 16'(k) || id_valid !== 1'b1 || pc_mux_sel !== 1'b1 || stall !== 1'b0) begin
        errors++;
        $display("FAIL stream_%0d got pc=%h v=%b sel=%b stall=%b exp pc=%h v=1 sel=1 stall=0",
                 k, id_pc, id_valid, pc_mux_sel, stall, 16'(k));
      end
    end
    #2; sb_on = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stream_drain left=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_jump();
    fill_mem();
    mem[2] = mk(OP_J, 5'd0, 5'd0, 16'h0008);
    apply_reset();
    sb_push(0); sb_push(1); sb_push(2); sb_push(8); sb_push(9);
    sb_on = 1'b1;
    repeat (4) cyc();
    checks++;
    if (pc_mux_sel !== 1'b0 || jump_loc !== 16'h0008 || issue_valid !== 1'b1) begin
      errors++;
      $display("FAIL jump_redirect got sel=%b loc=%h iss=%b exp sel=0 loc=0008 iss=1", pc_mux_sel, jump_loc, issue_valid);
    end
    cyc();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jump_bubble got id_valid=%b exp=0", id_valid); end
    checks++; if (pc_mux_sel !== 1'b1) begin errors++; $display("FAIL jump_flush_sel got=%b exp=1", pc_mux_sel); end
    cyc();
    checks++; if (id_pc !== 16'h0008 || id_valid !== 1'b1) begin errors++; $display("FAIL jump_target got pc=%h v=%b exp 0008/1", id_pc, id_valid); end
    cyc();
    #2; sb_on = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL jump_drain left=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_load_use();
    logic [4:0] lw_rt [4] = '{5'd5, 5'd5, 5'd0, 5'd5};
    logic [4:0] add_rs[4] = '{5'd5, 5'd7, 5'd0, 5'd7};
    logic [4:0] add_rt[4] = '{5'd6, 5'd5, 5'd6, 5'd6};
    logic       exp_st[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      fill_mem();
      mem[1] = mk(OP_LW, 5'd3, lw_rt[c], 16'h0004);
      mem[2] = mk(6'h00, add_rs[c], add_rt[c], 16'h0820);
      apply_reset();
      sb_push(0); sb_push(1); sb_push(2); sb_push(3);
      sb_on = 1'b1;
      repeat (4) cyc();
      checks++;
      if (stall !== exp_st[c] || stall_pm !== exp_st[c] || issue_valid !== !exp_st[c] || id_pc !== 16'h0002) begin
        errors++;
        $display("FAIL lu_case%0d got stall=%b pm=%b iss=%b pc=%h exp stall=%b pm=%b iss=%b pc=0002",
                 c, stall, stall_pm, issue_valid, id_pc, exp_st[c], exp_st[c], !exp_st[c]);
      end
      if (exp_st[c]) begin
        cyc();
        checks++;
        if (stall !== 1'b0 || issue_valid !== 1'b1 || id_pc !== 16'h0002) begin
          errors++;
          $display("FAIL lu_release%0d got stall=%b iss=%b pc=%h exp 0/1/0002", c, stall, issue_valid, id_pc);
        end
      end
      cyc();
      #2; sb_on = 1'b0;
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL lu_drain%0d left=%0d exp=0", c, sb_q.size()); end
    end
  endtask

  task automatic test_branch_over_stall();
    fill_mem();
    mem[1] = mk(OP_LW, 5'd3, 5'd5, 16'h0004);
    mem[2] = mk(6'h00, 5'd5, 5'd6, 16'h0820);
    apply_reset();
    sb_push(0); sb_push(1); sb_push(2); sb_push(16'h20);
    sb_on = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    ex_br_taken  = 1'b1;
    ex_br_target = 16'h0020;
    #1;
    checks++;
    if (stall !== 1'b0 || stall_pm !== 1'b0 || pc_mux_sel !== 1'b0 || jump_loc !== 16'h0020) begin
      errors++;
      $display("FAIL br_over_stall got stall=%b pm=%b sel=%b loc=%h exp 0/0/0/0020", stall, stall_pm, pc_mux_sel, jump_loc);
    end
    @(negedge clk);
    ex_br_taken = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL br_bubble got id_valid=%b exp=0", id_valid); end
    cyc();
    checks++; if (id_pc !== 16'h0020 || id_valid !== 1'b1) begin errors++; $display("FAIL br_target got pc=%h v=%b exp 0020/1", id_pc, id_valid); end
    #2; sb_on = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL br_drain left=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_back_to_back();
    fill_mem();
    mem[2] = mk(OP_J, 5'd0, 5'd0, 16'h0008);
    apply_reset();
    sb_push(0); sb_push(1); sb_push(2); sb_push(16'h30);
    sb_on = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    ex_br_taken  = 1'b1;
    ex_br_target = 16'h0030;
    #1;
    checks++;
    if (pc_mux_sel !== 1'b0 || jump_loc !== 16'h0030 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_redirect got sel=%b loc=%h v=%b exp 0/0030/0", pc_mux_sel, jump_loc, id_valid);
    end
    @(negedge clk);
    ex_br_taken = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL b2b_restart got id_valid=%b exp=0", id_valid); end
    cyc();
    checks++; if (id_pc !== 16'h0030 || id_valid !== 1'b1) begin errors++; $display("FAIL b2b_target got pc=%h v=%b exp 0030/1", id_pc, id_valid); end
    #2; sb_on = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_drain left=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_reset_midstream();
    fill_mem();
    mem[2] = mk(OP_J, 5'd0, 5'd0, 16'h0008);
    apply_reset();
    repeat (5) cyc();
    ex_br_taken  = 1'b1;
    ex_br_target = 16'h0030;
    #1;
    checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL midflush_pre got sel=%b exp=0", pc_mux_sel); end
    reset = 1'b0;
    #1;
    checks++;
    if (pc_mux_sel !== 1'b1 || jump_loc !== 16'h0 || stall !== 1'b0 || id_valid !== 1'b0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflush_rst got sel=%b loc=%h st=%b v=%b iss=%b exp 1/0000/0/0/0", pc_mux_sel, jump_loc, stall, id_valid, issue_valid);
    end
    ex_br_taken = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL restart_boot got id_valid=%b exp=0", id_valid); end
    repeat (2) cyc();
    checks++; if (id_pc !== 16'h0000 || id_valid !== 1'b1) begin errors++; $display("FAIL restart_first got pc=%h v=%b exp 0000/1", id_pc, id_valid); end

    fill_mem();
    mem[1] = mk(OP_LW, 5'd3, 5'd5, 16'h0004);
    mem[2] = mk(6'h00, 5'd5, 5'd6, 16'h0820);
    apply_reset();
    repeat (4) cyc();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midstall_pre got stall=%b exp=1", stall); end
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || stall_pm !== 1'b0 || id_pc !== 16'h0 || id_ins !== 32'h0) begin
      errors++;
      $display("FAIL midstall_rst got st=%b pm=%b pc=%h ins=%h exp 0/0/0000/00000000", stall, stall_pm, id_pc, id_ins);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    ex_br_taken  = 1'b0;
    ex_br_target = 16'h0000;
    test_reset();
    test_stream();
    test_jump();
    test_load_use();
    test_branch_over_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
